// File: rtl/irq_arbiter_if.sv
// Bus and controller-handshake bundle for irq_arbiter: register bus (PrAddr/PrWD/PrWe/PrRD)
// plus the IntReq/IntID request and IntAck/IntEnd acknowledge pulses.
interface irq_arbiter_if;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWe;
  logic [31:0] PrRD;
  logic        IntAck;
  logic        IntEnd;
  logic        IntReq;
  logic [2:0]  IntID;

  modport master (
    output PrAddr, PrWD, PrWe, IntAck, IntEnd,
    input  PrRD, IntReq, IntID
  );

  modport slave (
    input  PrAddr, PrWD, PrWe, IntAck, IntEnd,
    output PrRD, IntReq, IntID
  );
endinterface

// File: rtl/irq_arbiter.sv
// Six-source edge-latched interrupt arbiter with fixed priority (index 0 highest) and one-deep service.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer on HWInt ahead of edge detection.
module irq_arbiter (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       HWInt,
  irq_arbiter_if.slave     bus
);

  localparam logic [29:0] ADDR_MASK = 30'h0000_1FC8;
  localparam logic [29:0] ADDR_PEND = 30'h0000_1FC9;
  localparam logic [29:0] ADDR_STAT = 30'h0000_1FCA;
  localparam logic [29:0] ADDR_CTRL = 30'h0000_1FCB;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state;
  logic [5:0]  mask;
  logic [5:0]  pend;
  logic [5:0]  isr;
  logic        ge;
  logic        int_req;
  logic [2:0]  int_id;

  logic [5:0]  hw_sample;
  logic [5:0]  hw_hist;
  logic [5:0]  rise;
  logic [1:0]  warm;
  logic        armed;

  logic        wr_mask, wr_pend, wr_ctrl;
  logic [5:0]  active;
  logic [2:0]  first_id;
  logic [5:0]  cur_bit;
  logic        ack_fire;
  logic [31:0] rd_data;
  logic        unused_wd;

`ifdef IRQ_SYNC_EN
  localparam logic [1:0] WARM_CYCLES = 2'd3;
  logic [5:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= HWInt;
      sync2 <= sync1;
    end
  end

  assign hw_sample = sync2;
`else
  localparam logic [1:0] WARM_CYCLES = 2'd1;

  assign hw_sample = HWInt;
`endif

  // History flops reset to 0, so lines already high at reset release would look like
  // rising edges; edge detection is held off until the sample pipeline has refilled.
  always_ff @(posedge clk) begin
    if (rst)
      warm <= '0;
    else if (warm != WARM_CYCLES)
      warm <= warm + 2'd1;
  end

  assign armed = (warm == WARM_CYCLES);
  assign rise  = hw_sample & ~hw_hist & {6{armed}};

  assign wr_mask = bus.PrWe && (bus.PrAddr == ADDR_MASK);
  assign wr_pend = bus.PrWe && (bus.PrAddr == ADDR_PEND);
  assign wr_ctrl = bus.PrWe && (bus.PrAddr == ADDR_CTRL);
  assign unused_wd = ^bus.PrWD[31:6];

  assign active   = pend & mask;
  assign ack_fire = (state == REQ) && bus.IntAck;

  always_comb begin
    first_id = 3'd7;
    for (int unsigned i = 6; i > 0; i--) begin
      if (active[i-1])
        first_id = 3'(i - 1);
    end
  end

  always_comb begin
    cur_bit = '0;
    for (int unsigned i = 0; i < 6; i++)
      cur_bit[i] = (int_id == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      ge   <= 1'b0;
    end else begin
      if (wr_mask)
        mask <= bus.PrWD[5:0];
      if (wr_ctrl)
        ge <= bus.PrWD[0];
    end
  end

  // New edges are OR-ed in last so a set beats a same-cycle W1C or acknowledge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_hist <= '0;
      pend    <= '0;
    end else begin
      hw_hist <= hw_sample;
      pend    <= (pend
                  & ~(wr_pend  ? bus.PrWD[5:0] : 6'b0)
                  & ~(ack_fire ? cur_bit       : 6'b0))
                 | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_id  <= 3'd7;
      isr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ge && (active != 6'b0)) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= first_id;
          end
        end
        REQ: begin
          // Acknowledge wins over withdrawal: the controller acted on an asserted IntReq.
          if (bus.IntAck) begin
            state   <= SERVICE;
            int_req <= 1'b0;
            isr     <= isr | cur_bit;
          end else if (!ge || ((mask & cur_bit) == 6'b0)) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= 3'd7;
          end
        end
        SERVICE: begin
          if (bus.IntEnd) begin
            state  <= IDLE;
            isr    <= '0;
            int_id <= 3'd7;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
          int_id  <= 3'd7;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.PrAddr)
      ADDR_MASK: rd_data[5:0] = mask;
      ADDR_PEND: rd_data[5:0] = pend;
      ADDR_STAT: begin
        rd_data[5:0]  = isr;
        rd_data[10:8] = int_id;
      end
      ADDR_CTRL: rd_data[0] = ge;
      default:   rd_data = '0;
    endcase
  end

  assign bus.PrRD   = rd_data;
  assign bus.IntReq = int_req;
  assign bus.IntID  = int_id;

endmodule
